// File: rtl/ram_sp_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sp_param_if
//  Function : Request/response bundle for the ram_sp_param single-port RAM.
//             The master drives access requests and clear commands, and the
//             slave returns read data plus busy/drop status.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_sp_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                  en;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W/8-1:0]   be;
  logic                  clr;
  logic [DATA_W-1:0]     dout;
  logic                  dout_valid;
  logic                  busy;
  logic                  drop;

  modport master (
    output en, we, addr, din, be, clr,
    input  dout, dout_valid, busy, drop
  );

  modport slave (
    input  en, we, addr, din, be, clr,
    output dout, dout_valid, busy, drop
  );
endinterface
`default_nettype wire

// File: rtl/ram_sp_param.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sp_param
//  Function : Parametrised single-port synchronous RAM with byte-enable
//             writes, a 1- or 2-cycle registered read path and a sequential
//             clear engine that sweeps every word to CLR_VAL after reset or
//             on command. Unserviceable requests are flagged on drop.
//  Revision : 1.0  initial release
// ============================================================================
module ram_sp_param #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 4,
  parameter int                DEPTH   = 12,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ram_sp_param_if.slave    bus
);

  localparam int NB = DATA_W / 8;

  localparam logic [0:0] C_ST_IDLE  = 1'b0;
  localparam logic [0:0] C_ST_CLEAR = 1'b1;

  // Address of the last word; the sweep ends after writing it.
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH - 1);
  // Depth widened by one bit so the range check also works at DEPTH=2**ADDR_W.
  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              drop_q, drop_d;

  logic              accept;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;
  logic              rd_out_valid;
  logic [DATA_W-1:0] rd_out_data;

  // A request is served only in IDLE, without a concurrent clr, and in range.
  assign accept  = bus.en && (state_q == C_ST_IDLE) && !bus.clr
                   && ({1'b0, bus.addr} < C_DEPTH);
  assign rd_data = mem_q[bus.addr];

  // Next-state logic: clear sweep sequencing, request arbitration, write port mux.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_addr  = bus.addr;
    mem_wdata = bus.din;
    mem_be    = bus.be;
    rd_en     = 1'b0;
    drop_d    = 1'b0;

    if (bus.clr) begin
      // clr (re)starts the sweep; this edge itself writes nothing.
      state_d = C_ST_CLEAR;
      ptr_d   = '0;
    end else if (state_q == C_ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = ptr_q;
      mem_wdata = CLR_VAL;
      mem_be    = '1;
      if (ptr_q == C_LAST) begin
        state_d = C_ST_IDLE;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end

    if (bus.en) begin
      if (accept) begin
        // Accepted accesses only occur in IDLE, so the sweep never shares the port.
        if (bus.we) begin
          mem_we = 1'b1;
        end else begin
          rd_en = 1'b1;
        end
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Read pipeline depth selection.
  if (RD_LAT == 2) begin : g_lat2
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;

    // Extra stage captures the array output; it only loads on a read.
    always_comb begin
      s1_valid_d = rd_en;
      s1_data_d  = rd_en ? rd_data : s1_data_q;
    end

    // Stage register; reset cancels an in-flight read.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign rd_out_valid = s1_valid_q;
    assign rd_out_data  = s1_data_q;
  end else begin : g_lat1
    assign rd_out_valid = rd_en;
    assign rd_out_data  = rd_data;
  end

  // Output register: dout only moves when a new result arrives.
  always_comb begin
    dout_valid_d = rd_out_valid;
    dout_d       = rd_out_valid ? rd_out_data : dout_q;
  end

  // Control and output flops; reset restarts the sweep and cancels pending results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= C_ST_CLEAR;
      ptr_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      drop_q       <= drop_d;
    end
  end

  // Storage array with per-byte write strobes; reset suppresses any write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state_q == C_ST_CLEAR);
  assign bus.drop       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_sp_param
//  Function : Scoreboard bench for ram_sp_param. Two instances share one
//             stimulus stream: A (RD_LAT=1, CLR_VAL=0) and
//             B (RD_LAT=2, CLR_VAL=0xFFFF). Expected reads and drops are
//             queued with the cycle they must appear in; monitors compare.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_sp_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        we  = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din  = '0;
  logic [1:0]  be   = '0;

  always #5 clk = ~clk;

  ram_sp_param_if #(.DATA_W(16), .ADDR_W(4)) bus_a ();
  ram_sp_param_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

  assign bus_a.en = en;   assign bus_b.en = en;
  assign bus_a.we = we;   assign bus_b.we = we;
  assign bus_a.addr = addr; assign bus_b.addr = addr;
  assign bus_a.din = din; assign bus_b.din = din;
  assign bus_a.be = be;   assign bus_b.be = be;
  assign bus_a.clr = clr; assign bus_b.clr = clr;

  ram_sp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_LAT(1), .CLR_VAL(16'h0000)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  ram_sp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .CLR_VAL(16'hFFFF)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  typedef struct { logic [15:0] data; int due; } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   dq_a[$];
  int   dq_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t ma, mb;
  int   da, db;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-result and drop monitors for instance A.
  always @(negedge clk) begin
    if (bus_a.dout_valid) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL rd_a: stray dout_valid at cyc %0d dout=%h, required none", cyc, bus_a.dout);
      end else begin
        ma = q_a.pop_front();
        if (bus_a.dout !== ma.data || cyc != ma.due) begin
          errors++;
          $display("FAIL rd_a: got %h at cyc %0d, required %h at cyc %0d", bus_a.dout, cyc, ma.data, ma.due);
        end
      end
    end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
      checks++; errors++;
      ma = q_a.pop_front();
      $display("FAIL rd_a: no dout_valid at cyc %0d, required %h", cyc, ma.data);
    end
    if (bus_a.drop) begin
      checks++;
      if (dq_a.size() == 0) begin
        errors++;
        $display("FAIL drop_a: got drop at cyc %0d, required none", cyc);
      end else begin
        da = dq_a.pop_front();
        if (da != cyc) begin
          errors++;
          $display("FAIL drop_a: got drop at cyc %0d, required at cyc %0d", cyc, da);
        end
      end
    end else if (dq_a.size() != 0 && dq_a[0] <= cyc) begin
      checks++; errors++;
      da = dq_a.pop_front();
      $display("FAIL drop_a: got no drop at cyc %0d, required at cyc %0d", cyc, da);
    end
  end

  // Read-result and drop monitors for instance B.
  always @(negedge clk) begin
    if (bus_b.dout_valid) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL rd_b: stray dout_valid at cyc %0d dout=%h, required none", cyc, bus_b.dout);
      end else begin
        mb = q_b.pop_front();
        if (bus_b.dout !== mb.data || cyc != mb.due) begin
          errors++;
          $display("FAIL rd_b: got %h at cyc %0d, required %h at cyc %0d", bus_b.dout, cyc, mb.data, mb.due);
        end
      end
    end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
      checks++; errors++;
      mb = q_b.pop_front();
      $display("FAIL rd_b: no dout_valid at cyc %0d, required %h", cyc, mb.data);
    end
    if (bus_b.drop) begin
      checks++;
      if (dq_b.size() == 0) begin
        errors++;
        $display("FAIL drop_b: got drop at cyc %0d, required none", cyc);
      end else begin
        db = dq_b.pop_front();
        if (db != cyc) begin
          errors++;
          $display("FAIL drop_b: got drop at cyc %0d, required at cyc %0d", cyc, db);
        end
      end
    end else if (dq_b.size() != 0 && dq_b[0] <= cyc) begin
      checks++; errors++;
      db = dq_b.pop_front();
      $display("FAIL drop_b: got no drop at cyc %0d, required at cyc %0d", cyc, db);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge; the request is
  // sampled at the next rising edge, whose index is cyc+1.
  task automatic rd(input int a, input logic [15:0] ea, input logic [15:0] eb, input bit skip_b);
    en = 1'b1; we = 1'b0; clr = 1'b0; addr = a[3:0];
    q_a.push_back('{ea, cyc + 1});
    if (!skip_b) q_b.push_back('{eb, cyc + 2});
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [15:0] d, input logic [1:0] b);
    en = 1'b1; we = 1'b1; clr = 1'b0; addr = a[3:0]; din = d; be = b;
    @(negedge clk);
  endtask

  task automatic rej(input int a, input bit w, input bit c);
    en = 1'b1; we = w; clr = c; addr = a[3:0]; din = 16'h2222; be = 2'b11;
    dq_a.push_back(cyc + 1);
    dq_b.push_back(cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b0; we = 1'b0; clr = 1'b0; rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges with busy high, starting at the current one.
  task automatic wait_busy(input int exp_len);
    int na, nb, guard;
    na = 0; nb = 0; guard = 0;
    en = 1'b0; we = 1'b0; clr = 1'b0; rst = 1'b0;
    while ((bus_a.busy || bus_b.busy) && guard < 60) begin
      if (bus_a.busy) na++;
      if (bus_b.busy) nb++;
      guard++;
      @(negedge clk);
    end
    chk("busy_len_a", na, exp_len);
    chk("busy_len_b", nb, exp_len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset sweep and defaults.
    @(negedge clk);
    chk("rst_busy_a", bus_a.busy, 1);       chk("rst_busy_b", bus_b.busy, 1);
    chk("rst_dout_a", bus_a.dout, 0);       chk("rst_dout_b", bus_b.dout, 0);
    chk("rst_valid_a", bus_a.dout_valid, 0); chk("rst_valid_b", bus_b.dout_valid, 0);
    chk("rst_drop_a", bus_a.drop, 0);       chk("rst_drop_b", bus_b.drop, 0);
    rst = 1'b0;
    wait_busy(12);
    for (int a = 0; a < 12; a++) rd(a, 16'h0000, 16'hFFFF, 1'b0);

    // Byte enables.
    wr(3, 16'hABCD, 2'b11);
    wr(3, 16'h1234, 2'b01);
    rd(3, 16'hAB34, 16'hAB34, 1'b0);

    // Latency with back-to-back reads.
    wr(7, 16'h5A5A, 2'b11);
    rd(7, 16'h5A5A, 16'h5A5A, 1'b0);
    rd(0, 16'h0000, 16'hFFFF, 1'b0);

    // Out of range, first illegal address, and be=0 write.
    rej(13, 1'b1, 1'b0);
    rej(13, 1'b0, 1'b0);
    rej(12, 1'b0, 1'b0);
    wr(3, 16'h0000, 2'b00);
    rd(3, 16'hAB34, 16'hAB34, 1'b0);
    rd(11, 16'h0000, 16'hFFFF, 1'b0);
    rd(0, 16'h0000, 16'hFFFF, 1'b0);
    idle(2);

    // Clear during traffic: read in flight, request on clr cycle, write while busy.
    wr(2, 16'h1111, 2'b11);
    rd(2, 16'h1111, 16'h1111, 1'b0);
    rej(5, 1'b0, 1'b1);
    rej(2, 1'b1, 1'b0);
    wait_busy(11);
    for (int a = 0; a < 12; a++) rd(a, 16'h0000, 16'hFFFF, 1'b0);
    idle(2);

    // Reset right behind a read, then reset again at sweep cycle 5.
    rd(4, 16'h0000, 16'h0000, 1'b1);
    en = 1'b1; we = 1'b0; addr = 4'd5; rst = 1'b1;
    @(negedge clk);
    idle(1);
    rej(1, 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    wait_busy(12);
    rd(3, 16'h0000, 16'hFFFF, 1'b0);
    rd(11, 16'h0000, 16'hFFFF, 1'b0);
    idle(4);

    chk("pending_rd_a", q_a.size(), 0);
    chk("pending_rd_b", q_b.size(), 0);
    chk("pending_drop_a", dq_a.size(), 0);
    chk("pending_drop_b", dq_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port synchronous RAM with byte-enable writes, a selectable 1- or 2-cycle registered read path, and a sequential clear engine. The clear engine sweeps every location to a fixed value after reset or on command. It replaces the fixed 8x8 scratch RAM in the lab datapath, giving wider words, deeper arrays and partial-word writes. Accesses that cannot be served are reported, never silently lost.

## Interface
- DATA_W, 16: word width; must be a multiple of 8.
- ADDR_W, 4: address width.
- DEPTH, 12: number of locations; 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- CLR_VAL, 0: DATA_W-bit value written by the clear sweep.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  access request, sampled each edge.
- we  in  1  1 = write, 0 = read (qualified by en).
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i covers din[8i+7:8i].
- clr  in  1  start clear sweep (single-cycle pulse or level).
- dout  out  DATA_W  read data.
- dout_valid  out  1  dout carries a new read result this cycle.
- busy  out  1  clear sweep in progress; accesses not accepted.
- drop  out  1  one-cycle pulse: the request sampled at the previous edge was rejected.

## Operation
- States: IDLE, CLEAR. Sweep pointer ptr is ADDR_W bits wide.
- rst at an edge: state <= CLEAR, ptr <= 0, dout <= 0, dout_valid <= 0, drop <= 0, read pipeline flushed. rst overrides every other input.
- CLEAR, each edge with rst=0:
  - mem[ptr] <= CLR_VAL, ptr <= ptr+1.
  - At ptr == DEPTH-1, after that write: state <= IDLE, ptr <= 0.
- clr=1 in CLEAR restarts the sweep at ptr=0. clr=1 in IDLE gives CLEAR, ptr=0.
  - dout is not changed.
  - Reads already in the pipeline complete normally.
  - Any request on the clr cycle is dropped.
- busy = (state == CLEAR), registered.
- Request accepted when en=1, busy=0, clr=0, rst=0 and addr < DEPTH.
- Request rejected when en=1 and any of busy=1, clr=1 or addr >= DEPTH. A rejected request:
  - causes no memory write and no dout_valid;
  - sets drop=1 for the next cycle.
- Accepted write: for each i with be[i]=1, mem[addr][8i+7:8i] <= din[8i+7:8i]. Other bytes are unchanged. be=0 is legal and accepted; it writes nothing and does not drop.
- Accepted read: the data is mem[addr] as it stood before the edge. No write can target it on the same edge, since the port is single-port.
- dout holds its last value whenever dout_valid=0.

## Timing
- RD_LAT=1:
  - read accepted at edge N;
  - dout and dout_valid=1 appear after edge N, visible during cycle N+1;
  - dout_valid is high for exactly one cycle per read.
- RD_LAT=2: one extra register stage, so results are visible in cycle N+2. Back-to-back reads give back-to-back valid results at full throughput.
- Throughput: one access per cycle in IDLE.
- Sweep length: exactly DEPTH edges after the rst/clr edge. busy deasserts in the cycle after the edge that writes DEPTH-1.
- The first accepted access is possible at edge DEPTH+1 after the rst/clr edge.
- rst mid-sweep or mid-read: sweep restarts and all pending dout_valid are cancelled.
- drop is asserted in the cycle after the rejected request.

## Test plan
- Reset sweep, defaults:
  - stimulus: rst high 1 cycle, then low;
  - response: busy=1 for 12 cycles then 0; reads of addr 0..11 return 0x0000, each with dout_valid one cycle after the request.
- Byte enables:
  - stimulus: write 0xABCD be=11 to addr 3, then 0x1234 be=01 to addr 3, then read addr 3;
  - response: dout=0xAB34.
- Latency:
  - stimulus: RD_LAT=2, write 0x5A5A to addr 7, then back-to-back reads of addr 7 and addr 0;
  - response: dout_valid high on cycles N+2 and N+3 with 0x5A5A then 0x0000.
- Out of range:
  - stimulus: DEPTH=12, write to addr 13, then read addr 13;
  - response: drop pulses each time, no dout_valid, mem[0..11] unchanged.
- Clear during traffic:
  - stimulus: CLR_VAL=0xFFFF, read addr 2 at edge N, clr at edge N+1, write attempted at edge N+2;
  - response: read completes with its old value, the write is dropped, and after 12 cycles every address reads 0xFFFF.
- Reset mid-sweep:
  - stimulus: rst again at sweep cycle 5;
  - response: ptr restarts, busy stays high another 12 cycles, no dout_valid emitted.
